// File: rtl/sram_ctrl_pkg.sv
// Types and constants shared by the SRAM controller and its request arbiter.
package sram_ctrl_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_e;

  typedef enum logic {
    CH_READ  = 1'b0,
    CH_WRITE = 1'b1
  } chan_e;

  function automatic chan_e other_chan(input chan_e c);
    return (c == CH_WRITE) ? CH_READ : CH_WRITE;
  endfunction

endpackage

// File: rtl/sram_req_arbiter.sv
// Picks the read or write channel when the controller is idle.
// SRAM_CTRL_ROUND_ROBIN_EN: alternate on ties instead of fixed write priority.
module sram_req_arbiter
  import sram_ctrl_pkg::*;
(
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
  input  logic  clk_i,
  input  logic  reset_i,
`endif
  input  logic  sample_i,
  input  logic  req_rd_i,
  input  logic  req_wr_i,
  output logic  grant_o,
  output chan_e chan_o
);

`ifdef SRAM_CTRL_ROUND_ROBIN_EN
  chan_e last_q;
`endif

  always_comb begin
    chan_o = CH_READ;
    if (req_rd_i && req_wr_i) begin
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
      chan_o = other_chan(last_q);
`else
      chan_o = CH_WRITE;
`endif
    end else if (req_wr_i) begin
      chan_o = CH_WRITE;
    end
  end

  assign grant_o = sample_i && (req_rd_i || req_wr_i);

`ifdef SRAM_CTRL_ROUND_ROBIN_EN
  // Invalid selections also move the pointer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q <= CH_READ;
    end else if (grant_o) begin
      last_q <= chan_o;
    end
  end
`endif

endmodule

// File: rtl/sram_controller.sv
// Single-word request interface to an asynchronous SRAM with programmable wait states.
// Build option SRAM_CTRL_ROUND_ROBIN_EN selects round-robin arbitration on ties.
//   state  | meaning
//   IDLE   | sample requests, latch channel/address/data, range check
//   SETUP  | address and ce_n driven, write data enabled
//   ACCESS | we_n or oe_n low for wait_states+1 cycles
//   HOLD   | strobes released, address/data held
//   DONE   | one-cycle ready or invalid pulse
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned data_width      = 16,
  parameter int unsigned sram_addr_width = 12,
  parameter int unsigned sram_capacity   = 4096,
  parameter int unsigned wait_states     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_sram_read,
  input  logic                       req_sram_write,
  input  logic [sram_addr_width-1:0] req_sram_read_addr,
  input  logic [sram_addr_width-1:0] req_sram_write_addr,
  input  logic [data_width-1:0]      data_to_sram,
  output logic                       sram_read_ready,
  output logic                       sram_write_ready,
  output logic                       sram_read_invalid,
  output logic                       sram_write_invalid,
  output logic [data_width-1:0]      data_from_sram,
  output logic [sram_addr_width-1:0] sram_addr,
  output logic [data_width-1:0]      sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [data_width-1:0]      sram_dq_in,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n
);

  localparam int unsigned CMP_W = (sram_addr_width > 32) ? sram_addr_width : 32;
  localparam logic [CMP_W-1:0] CAP_EXT = CMP_W'(sram_capacity);
  localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(wait_states);

  state_e                     state_q, state_d;
  chan_e                      chan_q, chan_d;
  logic [WAIT_CNT_W-1:0]      cnt_q, cnt_d;
  logic                       grant;
  chan_e                      sel_chan;
  logic [sram_addr_width-1:0] sel_addr;
  logic                       out_of_range;

  logic [sram_addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0]      dq_out_q, dq_out_d;
  logic [data_width-1:0]      dout_q, dout_d;
  logic dq_oe_q, dq_oe_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
  logic rd_inv_q, rd_inv_d, wr_inv_q, wr_inv_d;

  sram_req_arbiter u_arb (
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
    .clk_i    (clk),
    .reset_i  (reset),
`endif
    .sample_i (state_q == IDLE),
    .req_rd_i (req_sram_read),
    .req_wr_i (req_sram_write),
    .grant_o  (grant),
    .chan_o   (sel_chan)
  );

  assign sel_addr     = (sel_chan == CH_WRITE) ? req_sram_write_addr : req_sram_read_addr;
  assign out_of_range = CMP_W'(sel_addr) >= CAP_EXT;

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          chan_d  = sel_chan;
          state_d = out_of_range ? DONE : SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WS_LOAD;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin and pulse registers are loaded from the next state so they switch on the same edge.
  always_comb begin
    ce_n_d     = !(state_d inside {SETUP, ACCESS, HOLD});
    dq_oe_d    = !ce_n_d && (chan_d == CH_WRITE);
    we_n_d     = !((state_d == ACCESS) && (chan_d == CH_WRITE));
    oe_n_d     = !((state_d == ACCESS) && (chan_d == CH_READ));
    addr_d     = addr_q;
    dq_out_d   = dq_out_q;
    if ((state_q == IDLE) && (state_d == SETUP)) begin
      addr_d = sel_addr;
      if (chan_d == CH_WRITE) begin
        dq_out_d = data_to_sram;
      end
    end
    rd_ready_d = (state_q == HOLD) && (chan_q == CH_READ);
    wr_ready_d = (state_q == HOLD) && (chan_q == CH_WRITE);
    rd_inv_d   = (state_q == IDLE) && (state_d == DONE) && (chan_d == CH_READ);
    wr_inv_d   = (state_q == IDLE) && (state_d == DONE) && (chan_d == CH_WRITE);
    dout_d     = dout_q;
    if ((state_q == ACCESS) && (cnt_q == '0) && (chan_q == CH_READ)) begin
      dout_d = sram_dq_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      chan_q     <= CH_READ;
      cnt_q      <= '0;
      addr_q     <= '0;
      dq_out_q   <= '0;
      dout_q     <= '0;
      dq_oe_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_inv_q   <= 1'b0;
      wr_inv_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      dout_q     <= dout_d;
      dq_oe_q    <= dq_oe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_inv_q   <= rd_inv_d;
      wr_inv_q   <= wr_inv_d;
    end
  end

  assign sram_read_ready    = rd_ready_q;
  assign sram_write_ready   = wr_ready_q;
  assign sram_read_invalid  = rd_inv_q;
  assign sram_write_invalid = wr_inv_q;
  assign data_from_sram     = dout_q;
  assign sram_addr          = addr_q;
  assign sram_dq_out        = dq_out_q;
  assign sram_dq_oe         = dq_oe_q;
  assign sram_ce_n          = ce_n_q;
  assign sram_oe_n          = oe_n_q;
  assign sram_we_n          = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: timeline model checked every cycle plus literal latency/data checks.
module tb_sram_controller;
  localparam int DW  = 16;
  localparam int AW  = 13;
  localparam int CAP = 4096;
  localparam int WS  = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance: 13-bit address so out-of-range addresses exist
  logic          req_rd = 1'b0, req_wr = 1'b0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] wdata = '0;
  logic rd_ready, wr_ready, rd_inv, wr_inv;
  logic [DW-1:0] dout, dq_out, dq_in;
  logic [AW-1:0] s_addr;
  logic dq_oe, ce_n, oe_n, we_n;

  sram_controller #(.data_width(DW), .sram_addr_width(AW), .sram_capacity(CAP),
                    .wait_states(WS)) dut (
    .clk(clk), .reset(reset),
    .req_sram_read(req_rd), .req_sram_write(req_wr),
    .req_sram_read_addr(rd_addr), .req_sram_write_addr(wr_addr),
    .data_to_sram(wdata),
    .sram_read_ready(rd_ready), .sram_write_ready(wr_ready),
    .sram_read_invalid(rd_inv), .sram_write_invalid(wr_inv),
    .data_from_sram(dout), .sram_addr(s_addr), .sram_dq_out(dq_out),
    .sram_dq_oe(dq_oe), .sram_dq_in(dq_in),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n));

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  assign dq_in = (!ce_n && !oe_n) ? sram_mem[s_addr] : 16'hDEAD;
  always @(posedge clk) if (!ce_n && !we_n && dq_oe) sram_mem[s_addr] <= dq_out;

  // zero-wait-state instance, full 12-bit address space
  logic          req_rd0 = 1'b0;
  logic [11:0]   rd_addr0 = '0;
  logic rd_ready0, wr_ready0, rd_inv0, wr_inv0, dq_oe0, ce_n0, oe_n0, we_n0;
  logic [DW-1:0] dout0, dq_out0, dq_in0;
  logic [11:0]   s_addr0;
  logic [DW-1:0] mem0 [0:4095];

  sram_controller #(.data_width(DW), .sram_addr_width(12), .sram_capacity(4096),
                    .wait_states(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_sram_read(req_rd0), .req_sram_write(1'b0),
    .req_sram_read_addr(rd_addr0), .req_sram_write_addr(12'h000),
    .data_to_sram(16'h0000),
    .sram_read_ready(rd_ready0), .sram_write_ready(wr_ready0),
    .sram_read_invalid(rd_inv0), .sram_write_invalid(wr_inv0),
    .data_from_sram(dout0), .sram_addr(s_addr0), .sram_dq_out(dq_out0),
    .sram_dq_oe(dq_oe0), .sram_dq_in(dq_in0),
    .sram_ce_n(ce_n0), .sram_oe_n(oe_n0), .sram_we_n(we_n0));

  assign dq_in0 = (!ce_n0 && !oe_n0) ? mem0[s_addr0] : 16'hDEAD;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model: one transaction timeline, measured from its accept cycle
  logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
  bit            busy = 0, m_wr = 0, m_inv = 0, last_wr = 0;
  int            t0 = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0, exp_dout = '0;

  bit rd_seen = 0, wr_seen = 0, prev_ce = 1;
  int rr_cyc, wr_cyc, ri_cyc, wi_cyc;
  int rr_cnt = 0, wr_cnt = 0, ri_cnt = 0, wi_cnt = 0, burst_cnt = 0, we_low = 0;

  always @(negedge clk) begin : cmp
    int d, dend;
    bit e_rr, e_wr, e_ri, e_wi, e_ce, e_we, e_oe, e_oe_dq;
    if (reset) begin
      busy = 0; last_wr = 0; exp_dout = '0;
      chk("rst_ce_n", ce_n, 1); chk("rst_we_n", we_n, 1); chk("rst_oe_n", oe_n, 1);
      chk("rst_dq_oe", dq_oe, 0); chk("rst_dout", dout, 0);
      chk("rst_pulses", {rd_ready, wr_ready, rd_inv, wr_inv}, 0);
    end else begin
      e_rr = 0; e_wr = 0; e_ri = 0; e_wi = 0;
      e_ce = 1; e_we = 1; e_oe = 1; e_oe_dq = 0;
      d = 0; dend = 0;
      if (busy) begin
        d = cyc - t0;
        dend = m_inv ? 1 : 4 + WS;
        if (m_inv) begin
          if (d == 1) begin e_ri = !m_wr; e_wi = m_wr; end
        end else begin
          if (d >= 1 && d <= 3 + WS) begin
            e_ce = 0; e_oe_dq = m_wr;
            chk("addr", s_addr, m_addr);
            if (m_wr) chk("dq_out", dq_out, m_data);
          end
          if (d >= 2 && d <= 2 + WS) begin
            if (m_wr) e_we = 0; else e_oe = 0;
          end
          if (d == 3 + WS && !m_wr) exp_dout = mdl_mem[m_addr];
          if (d == 4 + WS) begin e_rr = !m_wr; e_wr = m_wr; end
        end
      end
      chk("ce_n", ce_n, e_ce); chk("we_n", we_n, e_we); chk("oe_n", oe_n, e_oe);
      chk("dq_oe", dq_oe, e_oe_dq);
      chk("rd_ready", rd_ready, e_rr); chk("wr_ready", wr_ready, e_wr);
      chk("rd_invalid", rd_inv, e_ri); chk("wr_invalid", wr_inv, e_wi);
      chk("data_from_sram", dout, exp_dout);
      if (busy && d >= dend) begin
        busy = 0;
      end else if (!busy && (req_rd || req_wr)) begin
        if (req_rd && req_wr) begin
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
          m_wr = !last_wr;
`else
          m_wr = 1;
`endif
        end else begin
          m_wr = req_wr;
        end
        last_wr = m_wr;
        m_addr  = m_wr ? wr_addr : rd_addr;
        m_data  = wdata;
        m_inv   = (m_addr >= CAP);
        if (m_wr && !m_inv) mdl_mem[m_addr] = m_data;
        t0 = cyc; busy = 1;
      end
    end
    if (rd_ready) begin rd_seen = 1; rr_cyc = cyc; rr_cnt++; end
    if (wr_ready) begin wr_seen = 1; wr_cyc = cyc; wr_cnt++; end
    if (rd_inv)   begin rd_seen = 1; ri_cyc = cyc; ri_cnt++; end
    if (wr_inv)   begin wr_seen = 1; wi_cyc = cyc; wi_cnt++; end
    if (!ce_n && prev_ce) burst_cnt++;
    if (!we_n) we_low++;
    prev_ce = ce_n;
  end

  int p0_n = 0;
  int p0_cyc [0:3];
  logic [DW-1:0] p0_dat [0:3];
  always @(negedge clk) if (rd_ready0 && p0_n < 4) begin
    p0_cyc[p0_n] = cyc; p0_dat[p0_n] = dout0; p0_n++;
  end

  // ---------------- stimulus
  task automatic tick();
    @(posedge clk); #1;
    if (rd_seen) begin req_rd = 0; rd_seen = 0; end
    if (wr_seen) begin req_wr = 0; wr_seen = 0; end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((req_rd || req_wr) && k < 100) begin tick(); k++; end
    if (req_rd || req_wr) begin
      vectors++; errors++;
      $display("FAIL %s timeout: requests still pending after 100 cycles", tag);
      req_rd = 0; req_wr = 0;
    end
    tick(); tick();
  endtask

  task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] dat,
                        output int n);
    tick();
    n = cyc;
    rr_cnt = 0; wr_cnt = 0; ri_cnt = 0; wi_cnt = 0; burst_cnt = 0; we_low = 0;
    if (wr) begin wr_addr = a; wdata = dat; req_wr = 1; end
    else    begin rd_addr = a; req_rd = 1; end
    wait_idle(wr ? "write" : "read");
  endtask

  initial begin
    int n, k;
    mem0[0] = 16'h1234;
    mem0[12'hFFF] = 16'hABCD;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ce_n", ce_n, 1);
    chk("reset_addr", s_addr, 0);
    reset = 0;

    access(1, 13'h010, 16'hBEEF, n);
    chk("wr_latency", wr_cyc - n, 5);
    chk("we_low_cycles", we_low, 2);
    chk("wr_ready_count", wr_cnt, 1);

    access(0, 13'h010, 16'h0000, n);
    chk("rd_latency", rr_cyc - n, 5);
    chk("rd_data_beef", dout, 16'hBEEF);
    chk("rd_ready_count", rr_cnt, 1);
    chk("rd_bursts", burst_cnt, 1);

    access(0, 13'h1000, 16'h0000, n);
    chk("rinv_latency", ri_cyc - n, 1);
    chk("rinv_count", ri_cnt, 1);
    chk("rinv_no_ready", rr_cnt, 0);
    chk("rinv_no_burst", burst_cnt, 0);
    chk("rinv_data_kept", dout, 16'hBEEF);

    access(1, 13'h1FFF, 16'h5555, n);
    chk("winv_latency", wi_cyc - n, 1);
    chk("winv_no_burst", burst_cnt, 0);

    access(1, 13'h0FFF, 16'hABCD, n);
    access(0, 13'h0FFF, 16'h0000, n);
    chk("rd_last_addr", dout, 16'hABCD);

    access(1, 13'h020, 16'h5A5A, n);
    tick();
    n = cyc;
    rd_addr = 13'h020; wr_addr = 13'h030; wdata = 16'h1111;
    req_rd = 1; req_wr = 1;
    wait_idle("both");
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
    chk("tie_write_first", (wr_cyc < rr_cyc), 0);
    chk("tie_gap", wr_cyc - rr_cyc, 6);
`else
    chk("tie_write_first", (wr_cyc < rr_cyc), 1);
    chk("tie_gap", rr_cyc - wr_cyc, 6);
`endif
    chk("tie_read_data", dout, 16'h5A5A);

    // reset while the write is in ACCESS
    tick();
    n = cyc;
    wr_cnt = 0;
    wr_addr = 13'h040; wdata = 16'h7777; req_wr = 1;
    while (cyc < n + 2) tick();
    chk("pre_rst_we_n", we_n, 0);
    #2 reset = 1;
    #1;
    chk("async_we_n", we_n, 1);
    chk("async_ce_n", ce_n, 1);
    chk("async_dq_oe", dq_oe, 0);
    req_wr = 0; wr_seen = 0; rd_seen = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    repeat (4) tick();
    chk("rst_no_wr_ready", wr_cnt, 0);

    access(1, 13'h050, 16'h2222, n);
    chk("post_rst_wr_latency", wr_cyc - n, 5);
    access(0, 13'h050, 16'h0000, n);
    chk("post_rst_rd_data", dout, 16'h2222);

    // zero wait states, back-to-back reads on the second instance
    @(posedge clk); #1;
    n = cyc; p0_n = 0; rd_addr0 = 12'h000; req_rd0 = 1;
    k = 0;
    while (p0_n < 2 && k < 50) begin
      @(posedge clk); #1; k++;
      if (p0_n == 1 && rd_addr0 == 12'h000) rd_addr0 = 12'hFFF;
    end
    req_rd0 = 0;
    chk("ws0_pulses", p0_n, 2);
    if (p0_n >= 2) begin
      chk("ws0_first_latency", p0_cyc[0] - n, 4);
      chk("ws0_spacing", p0_cyc[1] - p0_cyc[0], 5);
      chk("ws0_data0", p0_dat[0], 16'h1234);
      chk("ws0_data1", p0_dat[1], 16'hABCD);
    end
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
